// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding,
// default operand width and the matching bit-counter width.
package sub_pkg;

  // Default operand/result width in bits (legal range 2..32).
  localparam int DEFAULT_WIDTH = 8;

  // Width of the bit counter for the default operand width.
  localparam int CNT_W = $clog2(DEFAULT_WIDTH);

  // Controller states: waiting for operands, shifting bits, holding result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : sub_pkg

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: d = a - b - bin, with borrow-out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic a_xor_b;

  // Difference and borrow equations for one bit position.
  always_comb begin
    a_xor_b = a ^ b;
    d       = a_xor_b ^ bin;
    bout    = (~a & b) | (~a_xor_b & bin);
  end

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: {bout,diff} = a - b - bin, one bit per
// clock, LSB first. Operands enter and results leave over valid/ready
// handshakes; a new operation is only accepted once the previous result
// has been taken by the consumer.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  // Counter width for this instance; a WIDTH-bit operand needs indices
  // 0..WIDTH-1.
  localparam int LCL_CNT_W = $clog2(WIDTH);
  localparam logic [LCL_CNT_W-1:0] LAST_BIT = LCL_CNT_W'(WIDTH - 1);
  localparam logic [LCL_CNT_W-1:0] CNT_ONE  = LCL_CNT_W'(1);

  state_t               state_r;
  state_t               state_nxt_s;
  logic [WIDTH-1:0]     a_sh_r;
  logic [WIDTH-1:0]     b_sh_r;
  logic [WIDTH-1:0]     res_sh_r;
  logic [WIDTH-1:0]     diff_r;
  logic                 br_r;
  logic                 bout_r;
  logic                 out_valid_r;
  logic [LCL_CNT_W-1:0] cnt_r;

  logic                 fs_d_s;
  logic                 fs_bout_s;
  logic                 accept_s;
  logic                 last_bit_s;
  logic                 deliver_s;
  logic [WIDTH-1:0]     res_next_s;

  // The single bit-slice of arithmetic, fed by the operand LSBs and the
  // running borrow.
  full_subtractor u_full_sub (
    .a    (a_sh_r[0]),
    .b    (b_sh_r[0]),
    .bin  (br_r),
    .d    (fs_d_s),
    .bout (fs_bout_s)
  );

  // Handshake qualifiers and the next result-register image.
  always_comb begin
    accept_s   = (state_r == IDLE) && in_valid;
    last_bit_s = (state_r == RUN) && (cnt_r == LAST_BIT);
    deliver_s  = (state_r == DONE) && out_valid_r && out_ready;
    res_next_s = {fs_d_s, res_sh_r[WIDTH-1:1]};
  end

  // Next-state selection for the IDLE -> RUN -> DONE -> IDLE sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (last_bit_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        if (deliver_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand shift registers, running borrow and bit counter. Operands are
  // captured only on the accept edge so later input changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_r   <= '0;
      b_sh_r   <= '0;
      res_sh_r <= '0;
      br_r     <= 1'b0;
      cnt_r    <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_sh_r   <= a;
            b_sh_r   <= b;
            res_sh_r <= '0;
            br_r     <= bin;
            cnt_r    <= '0;
          end
        end
        RUN: begin
          a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
          res_sh_r <= res_next_s;
          br_r     <= fs_bout_s;
          cnt_r    <= cnt_r + CNT_ONE;
        end
        DONE: begin
          cnt_r <= '0;
        end
        default: begin
          a_sh_r   <= '0;
          b_sh_r   <= '0;
          res_sh_r <= '0;
          br_r     <= 1'b0;
          cnt_r    <= '0;
        end
      endcase
    end
  end

  // Result registers: loaded on the final bit so diff/bout stay stable
  // while the consumer stalls and keep their value until the next result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      diff_r <= '0;
      bout_r <= 1'b0;
    end else if (last_bit_s) begin
      diff_r <= res_next_s;
      bout_r <= fs_bout_s;
    end
  end

  // Result-valid flag: raised with the final bit, dropped on handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
    end else if (last_bit_s) begin
      out_valid_r <= 1'b1;
    end else if (deliver_s) begin
      out_valid_r <= 1'b0;
    end
  end

  // Output drive; in_ready is held low while reset is applied.
  always_comb begin
    in_ready  = (state_r == IDLE) && !rst;
    out_valid = out_valid_r;
    diff      = diff_r;
    bout      = bout_r;
  end

endmodule : serial_subtractor
